// File: rtl/udp_tx_packer.sv
// udp_tx_packer: buffers a 32-bit result stream in a word FIFO and cuts it into UDP
// payloads. A payload closes on s_last, on reaching MAX_PKT_WORDS, or after an idle
// timeout. A one-hot TX FSM hands each closed payload to the UDP TX stage one word per
// tx_request. It then waits for tx_done and an inter-packet gap before the next payload.
// IFG_CYC must be at least 2, because the IDLE cycle counts as one of the gap cycles.
module udp_tx_packer #(
   parameter int FIFO_AW       = 9,
   parameter int LEN_AW        = 2,
   parameter int MAX_PKT_WORDS = 368,
   parameter int TIMEOUT_CYC   = 65535,
   parameter int IFG_CYC       = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic        tx_start_en,
   output logic [15:0] tx_byte_num,
   input  logic        tx_request,
   output logic [31:0] tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic        req_err
);

   localparam int PW     = 9;
   localparam int TW     = $clog2(TIMEOUT_CYC + 1);
   localparam int GW     = $clog2(IFG_CYC + 1);
   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int LDEPTH = 1 << LEN_AW;

   typedef enum logic [4:0] {
      S_IDLE      = 5'b00001,
      S_START     = 5'b00010,
      S_SEND      = 5'b00100,
      S_WAIT_DONE = 5'b01000,
      S_GAP       = 5'b10000
   } state_t;

   state_t          state;

   logic [31:0]     data_mem [DEPTH];
   logic [FIFO_AW:0] d_wr_ptr, d_rd_ptr;
   logic            data_full, data_empty, data_pop;
   logic [31:0]     data_head;

   logic [PW-1:0]   len_mem [LDEPTH];
   logic [LEN_AW:0] l_wr_ptr, l_rd_ptr;
   logic            len_full, len_empty, len_push, len_pop;
   logic [PW-1:0]   len_push_val, len_head;

   logic            accept;
   logic [PW-1:0]   pkt_words, pkt_words_inc;
   logic [TW-1:0]   idle_cnt;
   logic            idle_expired;

   logic [PW-1:0]   sent, pkt_len;
   logic            last_req;
   logic [GW-1:0]   gap_cnt;

   // Full when the wrap bits differ and the index bits match; empty when the pointers are equal.
   assign data_full  = (d_wr_ptr[FIFO_AW] != d_rd_ptr[FIFO_AW]) &&
                       (d_wr_ptr[FIFO_AW-1:0] == d_rd_ptr[FIFO_AW-1:0]);
   assign data_empty = (d_wr_ptr == d_rd_ptr);
   assign data_head  = data_mem[d_rd_ptr[FIFO_AW-1:0]];

   assign len_full   = (l_wr_ptr[LEN_AW] != l_rd_ptr[LEN_AW]) &&
                       (l_wr_ptr[LEN_AW-1:0] == l_rd_ptr[LEN_AW-1:0]);
   assign len_empty  = (l_wr_ptr == l_rd_ptr);
   assign len_head   = len_mem[l_rd_ptr[LEN_AW-1:0]];

   assign s_ready       = !data_full && !len_full;
   assign accept        = s_valid && s_ready;
   assign pkt_words_inc = pkt_words + PW'(1);
   assign idle_expired  = (idle_cnt == TW'(TIMEOUT_CYC - 1));

   // The request that finds sent == len-1 is the last one. It is answered by the word
   // already on tx_data, so it does not pop.
   assign last_req = (sent == pkt_len - PW'(1));
   assign data_pop = !data_empty &&
                     ((state == S_START) || (state == S_SEND && tx_request && !last_req));
   assign len_pop  = (state == S_IDLE) && !len_empty;

   // Close decision: an accept-driven close (s_last or max size) or an idle timeout.
   // An accept in the expiry cycle restarts the timer instead of closing.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      len_push     = 1'b0;
      len_push_val = pkt_words;
      if (accept) begin
         len_push_val = pkt_words_inc;
         len_push     = s_last || (pkt_words_inc == PW'(MAX_PKT_WORDS));
      end else if ((pkt_words != '0) && idle_expired && !len_full) begin
         len_push = 1'b1;
      end
   end

   // Storage writes for both FIFOs.
   // NOTE: storage arrays carry no reset; the reset pointers alone make the FIFOs empty.
   always_ff @(posedge clk) begin
      if (accept)   data_mem[d_wr_ptr[FIFO_AW-1:0]] <= s_data;
      if (len_push) len_mem[l_wr_ptr[LEN_AW-1:0]]   <= len_push_val;
   end

   // FIFO pointers; simultaneous write and read leave the occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         d_wr_ptr <= '0;
         d_rd_ptr <= '0;
         l_wr_ptr <= '0;
         l_rd_ptr <= '0;
      end else begin
         if (accept)   d_wr_ptr <= d_wr_ptr + (FIFO_AW+1)'(1);
         if (data_pop) d_rd_ptr <= d_rd_ptr + (FIFO_AW+1)'(1);
         if (len_push) l_wr_ptr <= l_wr_ptr + (LEN_AW+1)'(1);
         if (len_pop)  l_rd_ptr <= l_rd_ptr + (LEN_AW+1)'(1);
      end
   end

   // Open-packet word count and idle timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_words <= '0;
         idle_cnt  <= '0;
      end else if (accept) begin
         idle_cnt  <= '0;
         pkt_words <= len_push ? '0 : pkt_words_inc;
      end else if (len_push) begin
         idle_cnt  <= '0;
         pkt_words <= '0;
      end else if ((pkt_words != '0) && !idle_expired) begin
         idle_cnt  <= idle_cnt + TW'(1);
      end
   end

   // TX FSM with registered outputs: load length, pulse start, serve words, await done, gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         tx_start_en <= 1'b0;
         tx_byte_num <= '0;
         tx_data     <= '0;
         busy        <= 1'b0;
         req_err     <= 1'b0;
         sent        <= '0;
         pkt_len     <= '0;
         gap_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!len_empty) begin
                  pkt_len     <= len_head;
                  tx_byte_num <= 16'({len_head, 2'b00});
                  tx_start_en <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_START;
               end
            end
            S_START: begin
               tx_start_en <= 1'b0;
               tx_data     <= data_head;
               sent        <= '0;
               state       <= S_SEND;
            end
            S_SEND: begin
               if (tx_request) begin
                  if (last_req) begin
                     state <= S_WAIT_DONE;
                  end else begin
                     tx_data <= data_head;
                     sent    <= sent + PW'(1);
                  end
               end
            end
            S_WAIT_DONE: begin
               if (tx_request) req_err <= 1'b1;
               if (tx_done) begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GW'(IFG_CYC - 2)) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: begin
               tx_start_en <= 1'b0;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule
